// File: rtl/aer_event_scheduler.sv
// AER event scheduler: merges external 4-phase AER requests with internal spike
// feedback (through a small FIFO) into one registered event stream with round-robin arbitration.
module aer_event_scheduler #(
  parameter int M          = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         OPEN_LOOP,
  input  logic [M-1:0] MAX_NEUR,
  input  logic         AERIN_REQ,
  input  logic [M-1:0] AERIN_ADDR,
  output logic         AERIN_ACK,
  input  logic         SPK_VALID,
  input  logic [M-1:0] SPK_ADDR,
  output logic         EVT_VALID,
  output logic [M-1:0] EVT_ADDR,
  output logic         EVT_SRC,
  input  logic         EVT_READY,
  output logic [7:0]   DROP_CNT
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_ACK_HI = 1'b1;

  logic           req_meta_r;
  logic           req_sync_r;
  logic [0:0]     state_r;
  logic           ext_pending_r;
  logic [M-1:0]   ext_addr_r;
  logic [M-1:0]   fifo_mem_r [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [AW:0]    count_r;
  logic           last_ext_r;

  logic fifo_empty_s;
  logic fifo_full_s;
  logic push_req_s;
  logic push_s;
  logic pop_s;
  logic drop_s;
  logic load_en_s;
  logic capture_s;
  logic grant_ext_s;
  logic grant_int_s;

  assign fifo_empty_s = (count_r == {(AW + 1){1'b0}});
  assign fifo_full_s  = (count_r == FULL_CNT);
  assign push_req_s   = SPK_VALID && !OPEN_LOOP && (SPK_ADDR <= MAX_NEUR);
  assign load_en_s    = !EVT_VALID || EVT_READY;
  assign capture_s    = (state_r == ST_IDLE) && req_sync_r && !ext_pending_r;
  assign pop_s        = grant_int_s;
  assign push_s       = push_req_s && (!fifo_full_s || pop_s);
  assign drop_s       = push_req_s && fifo_full_s && !pop_s;

  // Round-robin grant into the output stage; last_ext_r resets low so external wins the first tie
  always_comb begin
    grant_ext_s = 1'b0;
    grant_int_s = 1'b0;
    if (load_en_s) begin
      if (ext_pending_r && !fifo_empty_s) begin
        grant_ext_s = !last_ext_r;
        grant_int_s = last_ext_r;
      end else begin
        grant_ext_s = ext_pending_r;
        grant_int_s = !fifo_empty_s;
      end
    end else begin
      grant_ext_s = 1'b0;
      grant_int_s = 1'b0;
    end
  end

  // Two-flop synchroniser for the asynchronous request
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      req_meta_r <= 1'b0;
      req_sync_r <= 1'b0;
    end else begin
      req_meta_r <= AERIN_REQ;
      req_sync_r <= req_meta_r;
    end
  end

  // Handshake FSM; the address is taken straight off the bus since it is stable while REQ is high
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_r       <= ST_IDLE;
      AERIN_ACK     <= 1'b0;
      ext_pending_r <= 1'b0;
      ext_addr_r    <= {M{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (capture_s) begin
            state_r   <= ST_ACK_HI;
            AERIN_ACK <= 1'b1;
          end else begin
            AERIN_ACK <= 1'b0;
          end
        end
        ST_ACK_HI: begin
          if (!req_sync_r) begin
            state_r   <= ST_IDLE;
            AERIN_ACK <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          AERIN_ACK <= 1'b0;
        end
      endcase
      if (capture_s) begin
        ext_pending_r <= 1'b1;
        ext_addr_r    <= AERIN_ADDR;
      end else if (grant_ext_s) begin
        ext_pending_r <= 1'b0;
      end
    end
  end

  // FIFO storage (contents are don't-care while empty)
  always_ff @(posedge CLK) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= SPK_ADDR;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {(AW + 1){1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + {{(AW - 1){1'b0}}, 1'b1};
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + {{AW{1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{AW{1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered output stage
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      EVT_VALID  <= 1'b0;
      EVT_ADDR   <= {M{1'b0}};
      EVT_SRC    <= 1'b0;
      last_ext_r <= 1'b0;
    end else if (load_en_s) begin
      if (grant_ext_s) begin
        EVT_VALID  <= 1'b1;
        EVT_ADDR   <= ext_addr_r;
        EVT_SRC    <= 1'b1;
        last_ext_r <= 1'b1;
      end else if (grant_int_s) begin
        EVT_VALID  <= 1'b1;
        EVT_ADDR   <= fifo_mem_r[rd_ptr_r];
        EVT_SRC    <= 1'b0;
        last_ext_r <= 1'b0;
      end else begin
        EVT_VALID  <= 1'b0;
      end
    end
  end

  // Saturating count of feedback spikes lost to a full FIFO
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      DROP_CNT <= 8'd0;
    end else if (drop_s && (DROP_CNT != 8'hFF)) begin
      DROP_CNT <= DROP_CNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_aer_event_scheduler.sv
// Self-checking bench for aer_event_scheduler: a table of per-cycle vectors plus
// hand-written sequences for arbitration, saturation, drain and mid-handshake reset.
module tb_aer_event_scheduler;

  logic       CLK = 1'b0;
  logic       RST;
  logic       OPEN_LOOP;
  logic [7:0] MAX_NEUR;
  logic       AERIN_REQ;
  logic [7:0] AERIN_ADDR;
  logic       AERIN_ACK;
  logic       SPK_VALID;
  logic [7:0] SPK_ADDR;
  logic       EVT_VALID;
  logic [7:0] EVT_ADDR;
  logic       EVT_SRC;
  logic       EVT_READY;
  logic [7:0] DROP_CNT;

  int n_cmp = 0;
  int n_err = 0;

  aer_event_scheduler #(.M(8), .FIFO_DEPTH(4)) dut (
    .CLK(CLK), .RST(RST), .OPEN_LOOP(OPEN_LOOP), .MAX_NEUR(MAX_NEUR),
    .AERIN_REQ(AERIN_REQ), .AERIN_ADDR(AERIN_ADDR), .AERIN_ACK(AERIN_ACK),
    .SPK_VALID(SPK_VALID), .SPK_ADDR(SPK_ADDR),
    .EVT_VALID(EVT_VALID), .EVT_ADDR(EVT_ADDR), .EVT_SRC(EVT_SRC),
    .EVT_READY(EVT_READY), .DROP_CNT(DROP_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic       ol;
    logic [7:0] max;
    logic       rdy;
    logic       req;
    logic [7:0] aaddr;
    logic       sv;
    logic [7:0] saddr;
    logic       e_ack;
    logic       e_val;
    logic [7:0] e_addr;
    logic       e_src;
    logic [7:0] e_drop;
  } vec_t;

  vec_t tab[$];

  function automatic vec_t mk(input logic ol, input logic [7:0] max, input logic rdy,
                              input logic req, input logic [7:0] aaddr,
                              input logic sv, input logic [7:0] saddr,
                              input logic e_ack, input logic e_val, input logic [7:0] e_addr,
                              input logic e_src, input logic [7:0] e_drop);
    vec_t v;
    v.ol = ol; v.max = max; v.rdy = rdy; v.req = req; v.aaddr = aaddr;
    v.sv = sv; v.saddr = saddr; v.e_ack = e_ack; v.e_val = e_val;
    v.e_addr = e_addr; v.e_src = e_src; v.e_drop = e_drop;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    tick();
    tick();
    RST = 1'b0;
  endtask

  initial begin
    bit saw_valid;
    RST = 1'b1; OPEN_LOOP = 1'b0; MAX_NEUR = 8'hFF; AERIN_REQ = 1'b0; AERIN_ADDR = 8'h00;
    SPK_VALID = 1'b0; SPK_ADDR = 8'h00; EVT_READY = 1'b1;

    // Vectors: ol, max, rdy, req, aaddr, sv, saddr | ack, valid, addr, src, drop
    // External 0x2A: ACK on 3rd edge, event on 4th, ACK drops 3 edges after REQ falls
    tab.push_back(mk(0, 8'hFF, 1, 1, 8'h2A, 0, 8'h00, 0, 0, 8'h00, 0, 8'd0));
    tab.push_back(mk(0, 8'hFF, 1, 1, 8'h2A, 0, 8'h00, 0, 0, 8'h00, 0, 8'd0));
    tab.push_back(mk(0, 8'hFF, 1, 1, 8'h2A, 0, 8'h00, 1, 0, 8'h00, 0, 8'd0));
    tab.push_back(mk(0, 8'hFF, 1, 1, 8'h2A, 0, 8'h00, 1, 1, 8'h2A, 1, 8'd0));
    tab.push_back(mk(0, 8'hFF, 1, 1, 8'h2A, 0, 8'h00, 1, 0, 8'h00, 0, 8'd0));
    tab.push_back(mk(0, 8'hFF, 1, 0, 8'h2A, 0, 8'h00, 1, 0, 8'h00, 0, 8'd0));
    tab.push_back(mk(0, 8'hFF, 1, 0, 8'h2A, 0, 8'h00, 1, 0, 8'h00, 0, 8'd0));
    tab.push_back(mk(0, 8'hFF, 1, 0, 8'h2A, 0, 8'h00, 0, 0, 8'h00, 0, 8'd0));
    tab.push_back(mk(0, 8'hFF, 1, 0, 8'h00, 0, 8'h00, 0, 0, 8'h00, 0, 8'd0));
    // MAX_NEUR=10: spikes 5,10 pass, 11 ignored without counting
    tab.push_back(mk(0, 8'd10, 1, 0, 8'h00, 1, 8'd5,  0, 0, 8'h00, 0, 8'd0));
    tab.push_back(mk(0, 8'd10, 1, 0, 8'h00, 1, 8'd10, 0, 1, 8'd5,  0, 8'd0));
    tab.push_back(mk(0, 8'd10, 1, 0, 8'h00, 1, 8'd11, 0, 1, 8'd10, 0, 8'd0));
    tab.push_back(mk(0, 8'd10, 1, 0, 8'h00, 0, 8'd0,  0, 0, 8'h00, 0, 8'd0));
    tab.push_back(mk(0, 8'd10, 1, 0, 8'h00, 0, 8'd0,  0, 0, 8'h00, 0, 8'd0));
    // READY low, spikes 1..6: output holds 1, FIFO 2..5, spike 6 dropped
    tab.push_back(mk(0, 8'hFF, 0, 0, 8'h00, 1, 8'd1, 0, 0, 8'h00, 0, 8'd0));
    tab.push_back(mk(0, 8'hFF, 0, 0, 8'h00, 1, 8'd2, 0, 1, 8'd1,  0, 8'd0));
    tab.push_back(mk(0, 8'hFF, 0, 0, 8'h00, 1, 8'd3, 0, 1, 8'd1,  0, 8'd0));
    tab.push_back(mk(0, 8'hFF, 0, 0, 8'h00, 1, 8'd4, 0, 1, 8'd1,  0, 8'd0));
    tab.push_back(mk(0, 8'hFF, 0, 0, 8'h00, 1, 8'd5, 0, 1, 8'd1,  0, 8'd0));
    tab.push_back(mk(0, 8'hFF, 0, 0, 8'h00, 1, 8'd6, 0, 1, 8'd1,  0, 8'd1));
    tab.push_back(mk(0, 8'hFF, 1, 0, 8'h00, 0, 8'd0, 0, 1, 8'd2,  0, 8'd1));
    tab.push_back(mk(0, 8'hFF, 1, 0, 8'h00, 0, 8'd0, 0, 1, 8'd3,  0, 8'd1));
    tab.push_back(mk(0, 8'hFF, 1, 0, 8'h00, 0, 8'd0, 0, 1, 8'd4,  0, 8'd1));
    tab.push_back(mk(0, 8'hFF, 1, 0, 8'h00, 0, 8'd0, 0, 1, 8'd5,  0, 8'd1));
    tab.push_back(mk(0, 8'hFF, 1, 0, 8'h00, 0, 8'd0, 0, 0, 8'h00, 0, 8'd1));

    // Reset state, sampled while RST is held
    #1;
    check("rst_ack", AERIN_ACK, 0);
    check("rst_valid", EVT_VALID, 0);
    check("rst_addr", EVT_ADDR, 0);
    check("rst_src", EVT_SRC, 0);
    check("rst_drop", DROP_CNT, 0);
    do_reset();

    for (int i = 0; i < tab.size(); i++) begin
      OPEN_LOOP = tab[i].ol; MAX_NEUR = tab[i].max; EVT_READY = tab[i].rdy;
      AERIN_REQ = tab[i].req; AERIN_ADDR = tab[i].aaddr;
      SPK_VALID = tab[i].sv; SPK_ADDR = tab[i].saddr;
      tick();
      check($sformatf("row%0d_ack", i), AERIN_ACK, tab[i].e_ack);
      check($sformatf("row%0d_valid", i), EVT_VALID, tab[i].e_val);
      check($sformatf("row%0d_drop", i), DROP_CNT, tab[i].e_drop);
      if (tab[i].e_val) begin
        check($sformatf("row%0d_addr", i), EVT_ADDR, tab[i].e_addr);
        check($sformatf("row%0d_src", i), EVT_SRC, tab[i].e_src);
      end
    end

    // Arbitration: output busy with 9, FIFO 3,4, external 0x80 pending
    do_reset();
    OPEN_LOOP = 1'b0; MAX_NEUR = 8'hFF; EVT_READY = 1'b0; AERIN_REQ = 1'b0;
    SPK_VALID = 1'b1; SPK_ADDR = 8'd9; tick();
    SPK_ADDR = 8'd3; tick();
    SPK_ADDR = 8'd4; tick();
    SPK_VALID = 1'b0;
    AERIN_REQ = 1'b1; AERIN_ADDR = 8'h80;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (AERIN_ACK) break;
    end
    check("arb_ack_seen", AERIN_ACK, 1);
    AERIN_REQ = 1'b0;
    tick();
    check("arb_hold_addr", EVT_ADDR, 8'd9);
    EVT_READY = 1'b1;
    tick();
    check("arb_ev1_addr", EVT_ADDR, 8'h80);
    check("arb_ev1_src", EVT_SRC, 1);
    tick();
    check("arb_ev2_addr", EVT_ADDR, 8'd3);
    check("arb_ev2_src", EVT_SRC, 0);
    tick();
    check("arb_ev3_addr", EVT_ADDR, 8'd4);
    check("arb_ev3_valid", EVT_VALID, 1);
    tick();
    check("arb_empty", EVT_VALID, 0);

    // Open loop blocks everything; then closed loop with READY low saturates drops
    do_reset();
    OPEN_LOOP = 1'b1; EVT_READY = 1'b1; saw_valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      SPK_VALID = 1'b1; SPK_ADDR = 8'(i);
      tick();
      if (EVT_VALID) saw_valid = 1'b1;
    end
    SPK_VALID = 1'b0; tick();
    check("ol_no_events", saw_valid, 0);
    check("ol_drop", DROP_CNT, 0);
    OPEN_LOOP = 1'b0; EVT_READY = 1'b0;
    for (int i = 0; i < 300; i++) begin
      SPK_VALID = 1'b1; SPK_ADDR = 8'(i);
      tick();
    end
    check("sat_drop", DROP_CNT, 8'd255);
    check("sat_hold_addr", EVT_ADDR, 8'd0);
    // OPEN_LOOP rising still drains queued spikes 1..4
    OPEN_LOOP = 1'b1; EVT_READY = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check($sformatf("drain%0d_addr", k), EVT_ADDR, k);
      check($sformatf("drain%0d_valid", k), EVT_VALID, 1);
    end
    tick();
    check("drain_done", EVT_VALID, 0);
    check("drain_drop", DROP_CNT, 8'd255);
    SPK_VALID = 1'b0; OPEN_LOOP = 1'b0;

    // Reset mid-handshake: asynchronous clear, still-high REQ becomes a new request
    do_reset();
    EVT_READY = 1'b0; AERIN_REQ = 1'b1; AERIN_ADDR = 8'h55;
    tick(); tick(); tick();
    check("mr_ack_before", AERIN_ACK, 1);
    tick();
    check("mr_valid_before", EVT_VALID, 1);
    #2 RST = 1'b1;
    #1;
    check("mr_async_ack", AERIN_ACK, 0);
    check("mr_async_valid", EVT_VALID, 0);
    tick();
    RST = 1'b0;
    tick();
    check("mr_post1_ack", AERIN_ACK, 0);
    tick();
    check("mr_post2_ack", AERIN_ACK, 0);
    tick();
    check("mr_post3_ack", AERIN_ACK, 1);
    tick();
    check("mr_new_addr", EVT_ADDR, 8'h55);
    check("mr_new_src", EVT_SRC, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
